// File: rtl/axi_ic_pkg.sv
// Shared interconnect types and sizes for the write-data scheduler.
// Entry layout grows len/beats fields when WR_SCHED_BEAT_CHECK_EN is defined.
package axi_ic_pkg;

  localparam int NUM_MST  = 2;
  localparam int NUM_SLV  = 2;
  localparam int SB_DEPTH = 4;

  localparam int MST_W = $clog2(NUM_MST);
  localparam int SLV_W = $clog2(NUM_SLV);
  localparam int PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [MST_W-1:0] mst;
    logic [SLV_W-1:0] slv;
`ifdef WR_SCHED_BEAT_CHECK_EN
    logic [3:0]       len;
    logic [4:0]       beats;
`endif
  } sb_entry_t;

endpackage

// File: rtl/wr_sched_elig.sv
// Combinational eligibility scan over the scoreboard, oldest entry first.
// Yields at most one grant per master and per slave, with the granted entry index.
module wr_sched_elig
  import axi_ic_pkg::*;
#(
  parameter int M     = NUM_MST,
  parameter int S     = NUM_SLV,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic [DEPTH-1:0]            i_live,
  input  logic [DEPTH-1:0][MST_W-1:0] i_mst,
  input  logic [DEPTH-1:0][SLV_W-1:0] i_slv,
  input  logic [PTR_W-1:0]            i_head,
  output logic [M-1:0]                o_grant,
  output logic [M-1:0][SLV_W-1:0]     o_sel,
  output logic [M-1:0][PTR_W-1:0]     o_idx
);

  logic [M-1:0]     w_busy_mst;
  logic [S-1:0]     w_busy_slv;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant    = '0;
    o_sel      = '0;
    o_idx      = '0;
    w_busy_mst = '0;
    w_busy_slv = '0;
    w_idx      = '0;
    // Every older not-done entry reserves its master and slave, granted or not.
    for (int a = 0; a < DEPTH; a++) begin
      w_idx = i_head + PTR_W'(a);
      if (i_live[w_idx]) begin
        if (!w_busy_mst[i_mst[w_idx]] && !w_busy_slv[i_slv[w_idx]]) begin
          o_grant[i_mst[w_idx]] = 1'b1;
          o_sel[i_mst[w_idx]]   = i_slv[w_idx];
          o_idx[i_mst[w_idx]]   = w_idx;
        end
        w_busy_mst[i_mst[w_idx]] = 1'b1;
        w_busy_slv[i_slv[w_idx]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_data_scheduler.sv
// W-channel scheduler: age-ordered AW scoreboard driving crossbar W select/enable.
// Define WR_SCHED_BEAT_CHECK_EN to store AWLEN per entry and flag beat-count errors.
module wr_data_scheduler
  import axi_ic_pkg::*;
#(
  parameter int M     = NUM_MST,
  parameter int S     = NUM_SLV,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [S-1:0]         AW_accept_f,
  input  logic [S*MST_W-1:0]   AW_mst_f,
  input  logic [S*4-1:0]       AW_len_f,
  input  logic [M-1:0]         W_valid_f,
  input  logic [M-1:0]         W_last_f,
  input  logic [S-1:0]         W_ready_f,
  output logic [M-1:0]         W_grant_f,
  output logic [M*SLV_W-1:0]   W_sel_f,
  output logic                 AW_block_f,
  output logic [PTR_W:0]       occupancy,
  output logic                 err_f
);

  localparam logic [PTR_W:0] BLOCK_AT = (PTR_W+1)'(DEPTH - S);

  sb_entry_t                   r_ent [DEPTH];
  logic [PTR_W:0]              r_head, r_tail;
  logic                        r_err;

  logic [DEPTH-1:0]            w_live;
  logic [DEPTH-1:0][MST_W-1:0] w_mst;
  logic [DEPTH-1:0][SLV_W-1:0] w_slv;
  logic [M-1:0]                w_grant;
  logic [M-1:0][SLV_W-1:0]     w_sel;
  logic [M-1:0][PTR_W-1:0]     w_gidx;
  logic [M-1:0]                w_hs;
  logic [PTR_W-1:0]            w_head_idx;
  logic                        w_retire;
  logic [S-1:0][PTR_W-1:0]     w_alloc_idx;
  logic [PTR_W:0]              w_acc_cnt;
  sb_entry_t                   w_new [S];
  logic                        w_beat_err;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_live[i] = r_ent[i].valid & ~r_ent[i].done;
      w_mst[i]  = r_ent[i].mst;
      w_slv[i]  = r_ent[i].slv;
    end
  end

  wr_sched_elig #(.M(M), .S(S), .DEPTH(DEPTH)) u_elig (
    .i_live  (w_live),
    .i_mst   (w_mst),
    .i_slv   (w_slv),
    .i_head  (w_head_idx),
    .o_grant (w_grant),
    .o_sel   (w_sel),
    .o_idx   (w_gidx)
  );

  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_retire   = r_ent[w_head_idx].valid & r_ent[w_head_idx].done;

  always_comb begin
    w_hs = '0;
    for (int m = 0; m < M; m++)
      w_hs[m] = w_grant[m] & W_valid_f[m] & W_ready_f[w_sel[m]];
  end

  // Simultaneous accepts take consecutive slots in ascending slave order.
  always_comb begin
    w_acc_cnt = '0;
    for (int s = 0; s < S; s++) begin
      w_alloc_idx[s] = r_tail[PTR_W-1:0] + w_acc_cnt[PTR_W-1:0];
      w_acc_cnt      = w_acc_cnt + (PTR_W+1)'(AW_accept_f[s]);
      w_new[s]       = '0;
      w_new[s].valid = 1'b1;
      w_new[s].mst   = AW_mst_f[s*MST_W +: MST_W];
      w_new[s].slv   = SLV_W'(s);
`ifdef WR_SCHED_BEAT_CHECK_EN
      w_new[s].len   = AW_len_f[s*4 +: 4];
`endif
    end
  end

`ifdef WR_SCHED_BEAT_CHECK_EN
  always_comb begin
    w_beat_err = 1'b0;
    for (int m = 0; m < M; m++) begin
      if (w_hs[m]) begin
        if (W_last_f[m] && (r_ent[w_gidx[m]].beats != {1'b0, r_ent[w_gidx[m]].len}))
          w_beat_err = 1'b1;
        if (!W_last_f[m] && (r_ent[w_gidx[m]].beats >= {1'b0, r_ent[w_gidx[m]].len}))
          w_beat_err = 1'b1;
      end
    end
  end
`else
  logic w_unused_len;
  assign w_unused_len = ^AW_len_f;
  assign w_beat_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (w_hs[m]) begin
          if (W_last_f[m]) r_ent[w_gidx[m]].done <= 1'b1;
`ifdef WR_SCHED_BEAT_CHECK_EN
          if (r_ent[w_gidx[m]].beats != 5'h1f)
            r_ent[w_gidx[m]].beats <= r_ent[w_gidx[m]].beats + 5'd1;
`endif
        end
      end
      // A granted entry is never done, so retire and beat updates never share a slot.
      if (w_retire) begin
        r_ent[w_head_idx] <= '0;
        r_head            <= r_head + (PTR_W+1)'(1);
      end
      if (|AW_accept_f) begin
        if (AW_block_f) begin
          r_err <= 1'b1;
        end else begin
          for (int s = 0; s < S; s++)
            if (AW_accept_f[s]) r_ent[w_alloc_idx[s]] <= w_new[s];
          r_tail <= r_tail + w_acc_cnt;
        end
      end
      if (w_beat_err) r_err <= 1'b1;
    end
  end

  assign occupancy  = r_tail - r_head;
  assign AW_block_f = occupancy > BLOCK_AT;
  assign W_grant_f  = w_grant;
  assign W_sel_f    = w_sel;
  assign err_f      = r_err;

endmodule

// File: tb/tb_wr_data_scheduler.sv
// Self-checking bench for wr_data_scheduler: directed scenarios plus random traffic
// compared each cycle against a queue-based model of outstanding bursts.
module tb_wr_data_scheduler;
  import axi_ic_pkg::*;

  localparam int M     = NUM_MST;
  localparam int S     = NUM_SLV;
  localparam int DEPTH = SB_DEPTH;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [S-1:0]         AW_accept_f;
  logic [S*MST_W-1:0]   AW_mst_f;
  logic [S*4-1:0]       AW_len_f;
  logic [M-1:0]         W_valid_f;
  logic [M-1:0]         W_last_f;
  logic [S-1:0]         W_ready_f;
  logic [M-1:0]         W_grant_f;
  logic [M*SLV_W-1:0]   W_sel_f;
  logic                 AW_block_f;
  logic [PTR_W:0]       occupancy;
  logic                 err_f;

  always #5 clk = ~clk;

  wr_data_scheduler #(.M(M), .S(S), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .AW_accept_f (AW_accept_f),
    .AW_mst_f    (AW_mst_f),
    .AW_len_f    (AW_len_f),
    .W_valid_f   (W_valid_f),
    .W_last_f    (W_last_f),
    .W_ready_f   (W_ready_f),
    .W_grant_f   (W_grant_f),
    .W_sel_f     (W_sel_f),
    .AW_block_f  (AW_block_f),
    .occupancy   (occupancy),
    .err_f       (err_f)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: outstanding bursts in AW order
  typedef struct {
    int mst;
    int slv;
    bit done;
    int beats;
    int len;
  } burst_t;

  burst_t q[$];
  bit     m_err;
  bit     exp_gnt [M];
  int     exp_sel [M];
  int     exp_qi  [M];

  // A master is served by its oldest unfinished burst, unless an even older
  // unfinished burst is still headed to the same slave.
  function automatic void m_eval();
    bit found;
    bit blocked;
    for (int m = 0; m < M; m++) begin
      exp_gnt[m] = 1'b0;
      exp_sel[m] = 0;
      exp_qi[m]  = -1;
      found      = 1'b0;
      for (int j = 0; j < q.size(); j++) begin
        if (!found && !q[j].done && q[j].mst == m) begin
          found   = 1'b1;
          blocked = 1'b0;
          for (int k = 0; k < j; k++)
            if (!q[k].done && q[k].slv == q[j].slv) blocked = 1'b1;
          if (!blocked) begin
            exp_gnt[m] = 1'b1;
            exp_sel[m] = q[j].slv;
            exp_qi[m]  = j;
          end
        end
      end
    end
  endfunction

  task automatic m_step();
    bit     ret;
    bit     blk;
    burst_t b;
    m_eval();
    ret = (q.size() > 0) && q[0].done;
    blk = (DEPTH - q.size()) < S;
    for (int m = 0; m < M; m++) begin
      if (exp_gnt[m] && W_valid_f[m] && W_ready_f[exp_sel[m]]) begin
        b = q[exp_qi[m]];
`ifdef WR_SCHED_BEAT_CHECK_EN
        b.beats++;
        if (W_last_f[m] && b.beats != b.len + 1) m_err = 1'b1;
        if (!W_last_f[m] && b.beats >= b.len + 1) m_err = 1'b1;
`endif
        if (W_last_f[m]) b.done = 1'b1;
        q[exp_qi[m]] = b;
      end
    end
    if (ret) void'(q.pop_front());
    if (AW_accept_f != '0) begin
      if (blk) m_err = 1'b1;
      else begin
        for (int s = 0; s < S; s++) begin
          if (AW_accept_f[s]) begin
            b.mst   = int'(AW_mst_f[s*MST_W +: MST_W]);
            b.slv   = s;
            b.done  = 1'b0;
            b.beats = 0;
            b.len   = int'(AW_len_f[s*4 +: 4]);
            q.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [M-1:0]       eg;
    logic [M*SLV_W-1:0] es;
    m_eval();
    eg = '0;
    es = '0;
    for (int m = 0; m < M; m++) begin
      eg[m]                  = exp_gnt[m];
      es[m*SLV_W +: SLV_W]   = SLV_W'(exp_sel[m]);
    end
    chk({tag, ".grant"}, 32'(W_grant_f), 32'(eg));
    chk({tag, ".sel"},   32'(W_sel_f),   32'(es));
    chk({tag, ".occ"},   32'(occupancy), 32'(q.size()));
    chk({tag, ".block"}, 32'(AW_block_f), 32'((DEPTH - q.size()) < S));
    chk({tag, ".err"},   32'(err_f),     32'(m_err));
  endtask

  task automatic idle();
    AW_accept_f = '0;
    AW_mst_f    = '0;
    AW_len_f    = '0;
    W_valid_f   = '0;
    W_last_f    = '0;
    W_ready_f   = '0;
  endtask

  // Inputs are driven just after a negedge; the model absorbs the edge, then outputs are compared.
  task automatic tick(input string tag);
    m_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 clr = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check_outputs({tag, ".in"});
    @(negedge clk);
    idle();
    clr = 1'b1;
    check_outputs({tag, ".rel"});
  endtask

  initial begin
    clr = 1'b0;
    idle();
    m_err = 1'b0;
    #1;
    check_outputs("por");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    check_outputs("rst_rel");

    // Single write M0 -> S1, four beats
    idle(); AW_accept_f = 2'b10; AW_mst_f = 2'b00; AW_len_f = 8'h30;
    tick("t1_aw");
    chk("t1_gnt", 32'(W_grant_f), 32'h1);
    chk("t1_sel", 32'(W_sel_f), 32'h1);
    idle(); W_valid_f = 2'b01; W_ready_f = 2'b10;
    for (int b = 0; b < 4; b++) begin
      W_last_f = (b == 3) ? 2'b01 : 2'b00;
      tick("t1_beat");
    end
    chk("t1_gnt_off", 32'(W_grant_f), 32'h0);
    chk("t1_occ_done", 32'(occupancy), 32'h1);
    idle();
    tick("t1_ret");
    chk("t1_occ_zero", 32'(occupancy), 32'h0);

    // Same-cycle accepts: S0 <- M1, S1 <- M0
    idle(); AW_accept_f = 2'b11; AW_mst_f = 2'b01;
    tick("t2_aw");
    chk("t2_gnt", 32'(W_grant_f), 32'h3);
    chk("t2_sel", 32'(W_sel_f), 32'h1);
    idle(); W_valid_f = 2'b11; W_last_f = 2'b11; W_ready_f = 2'b11;
    tick("t2_beat");
    idle();
    tick("t2_ret0");
    tick("t2_ret1");
    chk("t2_occ_zero", 32'(occupancy), 32'h0);

    // Ordering on one slave: M0 -> S0 then M1 -> S0
    idle(); AW_accept_f = 2'b01; AW_mst_f = 2'b00;
    tick("t3_aw0");
    AW_mst_f = 2'b01;
    tick("t3_aw1");
    chk("t3_gnt_first", 32'(W_grant_f), 32'h1);
    idle(); W_valid_f = 2'b11; W_ready_f = 2'b01;
    tick("t3_b0");
    chk("t3_gnt_hold", 32'(W_grant_f), 32'h1);
    W_last_f = 2'b01;
    tick("t3_b1");
    chk("t3_gnt_next", 32'(W_grant_f), 32'h2);
    chk("t3_sel_next", 32'(W_sel_f), 32'h0);
    W_valid_f = 2'b10; W_last_f = 2'b10;
    tick("t3_m1");
    idle();
    for (int i = 0; i < 3; i++) tick("t3_drain");
    chk("t3_occ_zero", 32'(occupancy), 32'h0);

    // Fill the scoreboard, then violate the block
    idle(); AW_accept_f = 2'b11; AW_mst_f = 2'b10;
    tick("t4_aw01");
    chk("t4_block_half", 32'(AW_block_f), 32'h0);
    tick("t4_aw23");
    chk("t4_occ_full", 32'(occupancy), 32'h4);
    chk("t4_block_full", 32'(AW_block_f), 32'h1);
    AW_accept_f = 2'b01;
    tick("t4_ovf");
    chk("t4_err", 32'(err_f), 32'h1);
    chk("t4_occ_kept", 32'(occupancy), 32'h4);
    idle(); W_valid_f = 2'b11; W_last_f = 2'b11; W_ready_f = 2'b11;
    for (int i = 0; i < 6; i++) tick("t4_drain");
    idle();
    tick("t4_idle");

    // Asynchronous reset in the middle of a burst
    idle(); AW_accept_f = 2'b10; AW_mst_f = 2'b00;
    tick("t5_aw");
    idle(); W_valid_f = 2'b01; W_ready_f = 2'b10;
    tick("t5_b0");
    #2 clr = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(W_grant_f), 32'h0);
    chk("t5_rst_sel", 32'(W_sel_f), 32'h0);
    chk("t5_rst_occ", 32'(occupancy), 32'h0);
    chk("t5_rst_blk", 32'(AW_block_f), 32'h0);
    chk("t5_rst_err", 32'(err_f), 32'h0);
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    idle();
    clr = 1'b1;
    tick("t5_after");
    chk("t5_occ_after", 32'(occupancy), 32'h0);

`ifdef WR_SCHED_BEAT_CHECK_EN
    // AWLEN=3 but WLAST on beat 2
    idle(); AW_accept_f = 2'b01; AW_mst_f = 2'b00; AW_len_f = 8'h03;
    tick("t6_aw");
    idle(); W_valid_f = 2'b01; W_ready_f = 2'b01;
    tick("t6_b0");
    W_last_f = 2'b01;
    tick("t6_b1");
    chk("t6_err", 32'(err_f), 32'h1);
    idle();
    tick("t6_ret");
    chk("t6_occ_zero", 32'(occupancy), 32'h0);
    async_reset("t6_rst");
`endif

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      AW_accept_f = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      if (((DEPTH - q.size()) < S) && ($urandom_range(0, 40) != 0)) AW_accept_f = '0;
      AW_mst_f = (S*MST_W)'($urandom);
      for (int s = 0; s < S; s++) AW_len_f[s*4 +: 4] = 4'($urandom_range(0, 3));
      W_valid_f = M'($urandom);
      for (int m = 0; m < M; m++) W_last_f[m] = ($urandom_range(0, 2) == 0);
      W_ready_f = S'($urandom);
      tick("rnd");
      if (c % 250 == 249) async_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wr_data_scheduler.md
# wr_data_scheduler

Write-data-channel scheduler for the 2x2 AXI interconnect. It records every AW handshake completed at a slave port in a DEPTH-entry age-ordered scoreboard and drives the per-master W-channel selector/enable pair of the crossbar. Each slave therefore receives write bursts in its own AW order, and each master's bursts go out in that master's AW order. It sits beside write_arbiter, which keeps AW and B routing, and replaces its W_grant_f/W_sel_f outputs.

## Interface
- M, 2, number of masters
- S, 2, number of slaves
- DEPTH, 4, scoreboard entries (max outstanding write bursts), power of two, ≥ S
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- AW_accept_f  in  S  per slave: S*_AWVALID & S*_AWREADY
- AW_mst_f  in  S*$clog2(M)  per slave: master index (upper $clog2(M) bits of S*_AWID)
- AW_len_f  in  S*4  per slave: S*_AWLEN (used only with checker)
- W_valid_f  in  M  per master: M*_WVALID
- W_last_f  in  M  per master: M*_WLAST
- W_ready_f  in  S  per slave: S*_WREADY
- W_grant_f  out  M  per master: data path enable (crossbar M*_write_data_en)
- W_sel_f  out  M*$clog2(S)  per master: target slave (crossbar M*_write_data_sel)
- AW_block_f  out  1  to write_arbiter: suppress all AW grants
- occupancy  out  $clog2(DEPTH)+1  live entries
- err_f  out  1  sticky beat-count error

## Operation
- Scoreboard: circular buffer, head/tail pointers, each entry {valid, done, mst, slv, len, beats}. Age = distance from head.
- Allocation: each set AW_accept_f[s] writes one entry at tail. Simultaneous accepts allocate in ascending slave index, so the lower index is older. Tail advances by the number of accepts.
- Eligibility: an entry is eligible when valid, not done, and no older not-done entry has the same mst or the same slv. This gives at most one eligible entry per master and per slave, so no arbitration is needed. The oldest not-done entry is always eligible, which makes the scheme deadlock-free.
- Grant: for an eligible entry (m,s), W_grant_f[m]=1 and W_sel_f[m]=s. A master with no eligible entry gets W_grant_f[m]=0 and W_sel_f[m]=0.
- Beat handshake for a granted (m,s): W_valid_f[m] & W_ready_f[s]. When that handshake carries W_last_f[m], set done on the entry.
- Retire: if the head entry is done, clear it and advance head by 1 per cycle.
- AW_block_f = (DEPTH − occupancy) < S. Accept while blocked is a protocol violation; the write is dropped and err_f is set.
- Widths: pointers $clog2(DEPTH) bits and wrap modulo DEPTH. occupancy = tail − head with an extra wrap bit.

## Timing
- Reset (clr=0, async): all entries invalid, head=tail=0, W_grant_f=0, W_sel_f=0, occupancy=0, AW_block_f=0, err_f=0. Reset mid-burst drops all outstanding entries immediately.
- Grants are combinational from registered scoreboard state only; there is no input-to-output comb path.
- AW accept at cycle t → entry valid at t+1 → W_grant_f asserted at t+1 if eligible.
- WLAST handshake at t → done at t+1 → grant drops and the next eligible entry is granted at t+1. There is no bubble between back-to-back bursts.
- Head retire lags done by ≥1 cycle. occupancy and AW_block_f update one cycle after retire.
- Full: occupancy=DEPTH gives AW_block_f=1. Retire and allocate in the same cycle are both applied.
- W_valid_f before the matching AW is simply not granted; WREADY stays low through the crossbar.

## Configuration
- WR_SCHED_BEAT_CHECK_EN defined:
  - Each entry stores AWLEN and counts beats.
  - WLAST on beat ≠ len+1 sets err_f.
  - A non-last beat at count len+1 also sets err_f.
  - The entry still retires on WLAST.
- Not defined: len/beats storage omitted and AW_len_f ignored. err_f is set only by the overflow case.

## Structure
- Shared package axi_ic_pkg: entry struct type, and constants MST_W=$clog2(M), SLV_W=$clog2(S), PTR_W=$clog2(DEPTH).
- Sub-module wr_sched_elig: purely combinational eligibility and one-hot grant derivation over the entry array. The top level holds pointers, entries and counters.

## Test plan
- Single write: M0→S1 accept, 4-beat burst → W_grant_f=2'b01, W_sel_f[0]=1 from t+1. After WLAST, grant=0 next cycle and occupancy returns to 0 two cycles after done.
- Same-cycle accepts: S0←M1 and S1←M0 → two entries, both eligible at t+1; W_grant_f=2'b11, W_sel_f={0,1}.
- Ordering: M0→S0 then M1→S0 → M1 is ungranted until M0's WLAST; M1 is granted the cycle after, with no bubble.
- Full: 4 accepts without data → AW_block_f=1 with occupancy=4. A fifth accept sets err_f.
- Reset mid-burst: clr low during beat 2 → all outputs at reset values asynchronously; after release, occupancy=0.
- With WR_SCHED_BEAT_CHECK_EN: AWLEN=3 and WLAST on beat 2 → err_f=1, and the entry retires.
